// File: rtl/decode_pkg.sv
// Shared decode constants: opcodes, ALU-select encodings, immediate formats
// and the combinational immediate/ALU decode helpers.
package decode_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
   } alu_sel_e;

   typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

   function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
      case (op)
         OP_IMM, OP_LOAD, OP_JALR: return IMM_I;
         OP_STORE:                 return IMM_S;
         OP_BRANCH:                return IMM_B;
         OP_LUI, OP_AUIPC:         return IMM_U;
         OP_JAL:                   return IMM_J;
         default:                  return IMM_R;
      endcase
   endfunction

   function automatic logic [31:0] imm32(input logic [31:0] i, input imm_fmt_e fmt);
      case (fmt)
         IMM_I:   return {{20{i[31]}}, i[31:20]};
         IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         IMM_U:   return {i[31:12], 12'b0};
         IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: return '0;
      endcase
   endfunction

   // inst[30] selects SUB only for register ops; for immediates it only marks SRAI.
   function automatic alu_sel_e alu_dec(input logic [6:0] op, input logic [2:0] f3,
                                        input logic b30);
      if (op == OP_LUI) return ALU_PASS_B;
      if (op != OP_REG && op != OP_IMM) return ALU_ADD;
      case (f3)
         3'd0:    return (op == OP_REG && b30) ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return b30 ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand select: x0 reads zero, select 0 or out-of-range reads the register
// file, otherwise the chosen forwarding source.
module fwd_mux #(
   parameter int XLEN = 32,
   parameter int NFWD = 3,
   parameter int SELW = $clog2(NFWD+1)
) (
   input  logic [4:0]         ra,
   input  logic [SELW-1:0]    sel,
   input  logic [XLEN-1:0]    reg_data,
   input  logic [NFWD*XLEN-1:0] fwd_data,
   output logic [XLEN-1:0]    data
);

   always_comb begin
      data = reg_data;
      for (int k = 1; k <= NFWD; k++)
         if (sel == SELW'(k)) data = fwd_data[(k-1)*XLEN +: XLEN];
      if (ra == 5'd0) data = '0;
   end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: combinational control/immediate decode and operand select,
// load-use stall detection, and a single registered output stage.
module decode_pipe
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NFWD = 3,
   parameter int SELW = $clog2(NFWD+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          inst,
   input  logic [XLEN-1:0]      pc_i,
   output logic [4:0]           ra1_o,
   output logic [4:0]           ra2_o,
   input  logic [XLEN-1:0]      reg1_i,
   input  logic [XLEN-1:0]      reg2_i,
   input  logic [SELW-1:0]      fwd_sel1_i,
   input  logic [SELW-1:0]      fwd_sel2_i,
   input  logic [NFWD*XLEN-1:0] fwd_data_i,
   input  logic                 ex_is_load_i,
   input  logic [4:0]           ex_wa_i,
   input  logic                 flush_i,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_pc,
   output logic [XLEN-1:0]      out_data1,
   output logic [XLEN-1:0]      out_data2,
   output logic [XLEN-1:0]      out_imm,
   output logic [XLEN-1:0]      out_br_target,
   output logic [4:0]           out_wa,
   output logic                 out_we,
   output logic [3:0]           out_alu_sel,
   output logic                 out_is_load,
   output logic                 stall_o
);

   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic            uses_rs1, uses_rs2, is_jalr, we, advance;
   logic [XLEN-1:0] imm, data1, data2, tgt_sum, br_target;
   alu_sel_e        alu_sel;

   assign opcode = inst[6:0];
   assign rd     = inst[11:7];
   assign ra1_o  = inst[19:15];
   assign ra2_o  = inst[24:20];

   assign uses_rs1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
   assign uses_rs2 = opcode inside {OP_REG, OP_STORE, OP_BRANCH};
   assign is_jalr  = (opcode == OP_JALR);
   assign we       = !(opcode inside {OP_BRANCH, OP_STORE}) && (rd != 5'd0);
   assign alu_sel  = alu_dec(opcode, inst[14:12], inst[30]);
   assign imm      = XLEN'($signed(imm32(inst, imm_fmt(opcode))));

   fwd_mux #(.XLEN(XLEN), .NFWD(NFWD), .SELW(SELW)) u_op1 (
      .ra(ra1_o), .sel(fwd_sel1_i), .reg_data(reg1_i), .fwd_data(fwd_data_i), .data(data1)
   );
   fwd_mux #(.XLEN(XLEN), .NFWD(NFWD), .SELW(SELW)) u_op2 (
      .ra(ra2_o), .sel(fwd_sel2_i), .reg_data(reg2_i), .fwd_data(fwd_data_i), .data(data2)
   );

   // JALR targets are computed from the forwarded rs1 and must be halfword-aligned.
   assign tgt_sum   = (is_jalr ? data1 : pc_i) + imm;
   assign br_target = is_jalr ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;

   assign advance  = !out_valid || out_ready;
   assign stall_o  = in_valid && ex_is_load_i && (ex_wa_i != 5'd0) &&
                     ((uses_rs1 && ex_wa_i == ra1_o) || (uses_rs2 && ex_wa_i == ra2_o));
   assign in_ready = flush_i || (advance && !stall_o);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_pc        <= '0;
         out_data1     <= '0;
         out_data2     <= '0;
         out_imm       <= '0;
         out_br_target <= '0;
         out_wa        <= '0;
         out_we        <= 1'b0;
         out_alu_sel   <= '0;
         out_is_load   <= 1'b0;
      end else if (flush_i) begin
         out_valid <= 1'b0;
         out_we    <= 1'b0;
      end else if (advance) begin
         if (in_valid && !stall_o) begin
            out_valid     <= 1'b1;
            out_pc        <= pc_i;
            out_data1     <= data1;
            out_data2     <= data2;
            out_imm       <= imm;
            out_br_target <= br_target;
            out_wa        <= rd;
            out_we        <= we;
            out_alu_sel   <= alu_sel;
            out_is_load   <= (opcode == OP_LOAD);
         end else begin
            out_valid <= 1'b0;
            out_we    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: hand-encoded instructions with hand-computed
// expected outputs, checked with immediate assertions.
module tb_decode_pipe;
   import decode_pkg::*;

   localparam int XLEN = 32;
   localparam int NFWD = 2;
   localparam int SELW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, in_valid, in_ready, ex_is_load_i, flush_i, out_valid, out_ready;
   logic out_we, out_is_load, stall_o;
   logic [31:0] inst;
   logic [XLEN-1:0] pc_i, reg1_i, reg2_i;
   logic [4:0] ra1_o, ra2_o, ex_wa_i, out_wa;
   logic [SELW-1:0] fwd_sel1_i, fwd_sel2_i;
   logic [NFWD*XLEN-1:0] fwd_data_i;
   logic [XLEN-1:0] out_pc, out_data1, out_data2, out_imm, out_br_target;
   logic [3:0] out_alu_sel;

   int checks = 0;
   int errors = 0;

   decode_pipe #(.XLEN(XLEN), .NFWD(NFWD), .SELW(SELW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
      .pc_i(pc_i), .ra1_o(ra1_o), .ra2_o(ra2_o), .reg1_i(reg1_i), .reg2_i(reg2_i),
      .fwd_sel1_i(fwd_sel1_i), .fwd_sel2_i(fwd_sel2_i), .fwd_data_i(fwd_data_i),
      .ex_is_load_i(ex_is_load_i), .ex_wa_i(ex_wa_i), .flush_i(flush_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_data1(out_data1), .out_data2(out_data2), .out_imm(out_imm),
      .out_br_target(out_br_target), .out_wa(out_wa), .out_we(out_we),
      .out_alu_sel(out_alu_sel), .out_is_load(out_is_load), .stall_o(stall_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; inst = '0; pc_i = '0; reg1_i = '0; reg2_i = '0;
      fwd_sel1_i = '0; fwd_sel2_i = '0; fwd_data_i = '0; ex_is_load_i = 1'b0;
      ex_wa_i = '0; flush_i = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_data1", out_data1, 0);
      chk("rst_imm", out_imm, 0);
      chk("rst_we", out_we, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b0;

      // ADDI x5,x1,7
      inst = 32'h0070_8293; pc_i = 32'h40; reg1_i = 32'd10; in_valid = 1'b1;
      #1;
      chk("addi_ra1", ra1_o, 1);
      chk("addi_in_ready", in_ready, 1);
      chk("addi_stall", stall_o, 0);
      tick();
      chk("addi_valid", out_valid, 1);
      chk("addi_data1", out_data1, 10);
      chk("addi_imm", out_imm, 7);
      chk("addi_wa", out_wa, 5);
      chk("addi_we", out_we, 1);
      chk("addi_pc", out_pc, 32'h40);
      chk("addi_alu", out_alu_sel, ALU_ADD);
      chk("addi_tgt", out_br_target, 32'h47);
      chk("addi_isload", out_is_load, 0);

      // forwarding: source 2, then x0, then out-of-range select
      fwd_sel1_i = 2'd2; fwd_data_i = {32'hDEAD_BEEF, 32'h1111_1111};
      tick();
      chk("fwd_src2", out_data1, 32'hDEAD_BEEF);
      inst = 32'h0070_0293;
      tick();
      chk("fwd_x0", out_data1, 0);
      inst = 32'h0070_8293; fwd_sel1_i = 2'd3;
      tick();
      chk("fwd_oor", out_data1, 10);
      fwd_sel1_i = 2'd0;

      // SUB x4,x3,x2
      inst = 32'h4021_8233; reg1_i = 32'd5; reg2_i = 32'd3;
      tick();
      chk("sub_alu", out_alu_sel, ALU_SUB);
      chk("sub_data2", out_data2, 3);
      chk("sub_imm", out_imm, 0);
      chk("sub_wa", out_wa, 4);

      // JALR x1,8(x2) with rs1=0x103
      inst = 32'h0081_00E7; reg1_i = 32'h103; pc_i = 32'h200;
      tick();
      chk("jalr_tgt", out_br_target, 32'h10A);
      chk("jalr_we", out_we, 1);
      chk("jalr_wa", out_wa, 1);

      // BEQ x1,x2,-4 at 0x100
      inst = 32'hFE20_8EE3; pc_i = 32'h100;
      tick();
      chk("beq_tgt", out_br_target, 32'hFC);
      chk("beq_imm", out_imm, 32'hFFFF_FFFC);
      chk("beq_we", out_we, 0);

      // SW x2,-8(x1)
      inst = 32'hFE20_AC23;
      tick();
      chk("sw_imm", out_imm, 32'hFFFF_FFF8);
      chk("sw_we", out_we, 0);

      // LUI x7,0x12345: rs1 field is 8, a load to x8 must not stall it
      inst = 32'h1234_53B7; ex_is_load_i = 1'b1; ex_wa_i = 5'd8;
      #1;
      chk("lui_nostall", stall_o, 0);
      tick();
      chk("lui_imm", out_imm, 32'h1234_5000);
      chk("lui_we", out_we, 1);
      chk("lui_valid", out_valid, 1);

      // load-use on rs2 then rs1 of ADD x4,x3,x2
      inst = 32'h0021_8233; ex_wa_i = 5'd2;
      #1;
      chk("stall_rs2", stall_o, 1);
      ex_wa_i = 5'd3;
      #1;
      chk("stall_rs1", stall_o, 1);
      chk("stall_in_ready", in_ready, 0);
      tick();
      chk("stall_bubble", out_valid, 0);
      chk("stall_bubble_we", out_we, 0);
      ex_is_load_i = 1'b0;
      #1;
      chk("unstall_in_ready", in_ready, 1);
      tick();
      chk("unstall_valid", out_valid, 1);
      chk("unstall_wa", out_wa, 4);

      // backpressure: hold ADDI result for 3 cycles
      inst = 32'h0070_8293; reg1_i = 32'd10;
      tick();
      out_ready = 1'b0; inst = 32'h0021_8233; reg1_i = 32'd77;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_in_ready", in_ready, 0);
         tick();
         chk("hold_valid", out_valid, 1);
         chk("hold_wa", out_wa, 5);
         chk("hold_data1", out_data1, 10);
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", in_ready, 1);
      tick();
      chk("release_wa", out_wa, 4);
      chk("release_data1", out_data1, 77);

      // flush with a stalled valid output and a presented instruction
      out_ready = 1'b0; flush_i = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 1);
      tick();
      chk("flush_valid", out_valid, 0);
      chk("flush_we", out_we, 0);
      flush_i = 1'b0; out_ready = 1'b1;

      // reset mid-stream
      inst = 32'h0070_8293; reg1_i = 32'd10; pc_i = 32'h40;
      tick();
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      tick();
      chk("midrst_valid", out_valid, 0);
      chk("midrst_pc", out_pc, 0);
      chk("midrst_data1", out_data1, 0);
      chk("midrst_imm", out_imm, 0);
      chk("midrst_wa", out_wa, 0);
      chk("midrst_tgt", out_br_target, 0);
      rst = 1'b0; in_valid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
